ir_burst_emitter: RTL and testbench

- Transmit-side counterpart to the team's digital-pin proximity readers.
- Drives an IR emitter LED with bursts of a 38 kHz-class square-wave carrier. Consecutive bursts are separated by dark gaps, so a demodulating IR proximity receiver can detect the reflection.
- A start/busy/done handshake lets a controller request N bursts.
- Sits between top-level control logic and the emitter output pin.

---
 rtl/ir_burst_emitter.sv | 142 ++++++++++++++
 tb/tb_ir_burst_emitter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ir_burst_emitter.sv
// IR emitter driver: n bursts of a square-wave carrier, each burst followed by a dark gap.
// Start/busy/done handshake; enable low aborts to idle on the next cycle without a done pulse.
module ir_burst_emitter #(
  parameter int HALF_DIV     = 157,
  parameter int BURST_CYCLES = 10,
  parameter int GAP_CYCLES   = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       start,
  input  logic [7:0] n_bursts,
  output logic       led_out,
  output logic       busy,
  output logic       done
);

  localparam int HW   = $clog2(HALF_DIV + 1);
  localparam int PMAX = (BURST_CYCLES > GAP_CYCLES) ? BURST_CYCLES : GAP_CYCLES;
  localparam int PW   = $clog2(PMAX + 1);

  localparam logic [HW-1:0] HALF_LAST  = HW'(HALF_DIV - 1);
  localparam logic [PW-1:0] BURST_LAST = PW'(BURST_CYCLES - 1);
  localparam logic [PW-1:0] GAP_LAST   = PW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [HW-1:0] half_cnt, half_cnt_n;
  logic [PW-1:0] per_cnt, per_cnt_n;
  logic          phase, phase_n;
  logic [7:0]    remaining, remaining_n;
  logic          led_n, busy_n, done_n;
  logic          half_end, period_end;
  logic [PW-1:0] per_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      half_cnt  <= '0;
      per_cnt   <= '0;
      phase     <= 1'b0;
      remaining <= '0;
      led_out   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      half_cnt  <= half_cnt_n;
      per_cnt   <= per_cnt_n;
      phase     <= phase_n;
      remaining <= remaining_n;
      led_out   <= led_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

  always_comb begin
    state_n     = state;
    half_cnt_n  = half_cnt;
    per_cnt_n   = per_cnt;
    phase_n     = phase;
    remaining_n = remaining;
    done_n      = 1'b0;

    half_end   = (half_cnt == HALF_LAST);
    // A period completes at the end of its low half; the gap runs the same phase clock.
    period_end = half_end && !phase;
    per_last   = (state == BURST) ? BURST_LAST : GAP_LAST;

    case (state)
      IDLE: begin
        if (start && enable) begin
          if (n_bursts != 8'd0) begin
            state_n     = BURST;
            remaining_n = n_bursts;
            half_cnt_n  = '0;
            per_cnt_n   = '0;
            phase_n     = 1'b1;
          end else begin
            done_n = 1'b1;
          end
        end
      end

      BURST, GAP: begin
        if (!enable) begin
          state_n     = IDLE;
          half_cnt_n  = '0;
          per_cnt_n   = '0;
          phase_n     = 1'b0;
          remaining_n = '0;
        end else begin
          if (half_end) begin
            half_cnt_n = '0;
            phase_n    = ~phase;
          end else begin
            half_cnt_n = half_cnt + HW'(1);
          end

          if (period_end) begin
            if (per_cnt == per_last) begin
              per_cnt_n = '0;
              phase_n   = 1'b1;
              if (state == BURST) begin
                state_n = GAP;
              end else begin
                remaining_n = remaining - 8'd1;
                if (remaining == 8'd1) begin
                  state_n = IDLE;
                  phase_n = 1'b0;
                  done_n  = 1'b1;
                end else begin
                  state_n = BURST;
                end
              end
            end else begin
              per_cnt_n = per_cnt + PW'(1);
            end
          end
        end
      end

      default: begin
        state_n     = IDLE;
        half_cnt_n  = '0;
        per_cnt_n   = '0;
        phase_n     = 1'b0;
        remaining_n = '0;
      end
    endcase

    led_n  = (state_n == BURST) && phase_n;
    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_ir_burst_emitter.sv
// Bench for ir_burst_emitter: elapsed-time reference model compared every cycle,
// directed scenarios with literal expectations, random traffic, and a default-parameter run.
module tb_ir_burst_emitter;

  localparam int H   = 2;
  localparam int B   = 3;
  localparam int G   = 2;
  localparam int PER = 2 * H;
  localparam int BL  = B * PER;
  localparam int SEQ = (B + G) * PER;

  logic       clk;
  logic       rst;
  logic       enable, start;
  logic [7:0] n_bursts;
  logic       led_out, busy, done;

  logic       en2, st2;
  logic [7:0] nb2;
  logic       led2, busy2, done2;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  bit m_active = 0;
  int m_t = 0;
  int m_n = 0;
  bit m_done = 0;

  ir_burst_emitter #(.HALF_DIV(H), .BURST_CYCLES(B), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst(rst), .enable(enable), .start(start), .n_bursts(n_bursts),
    .led_out(led_out), .busy(busy), .done(done)
  );

  ir_burst_emitter dut_def (
    .clk(clk), .rst(rst), .enable(en2), .start(st2), .n_bursts(nb2),
    .led_out(led2), .busy(busy2), .done(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: a sequence is just a count of elapsed busy cycles since acceptance.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      m_active = 0;
      m_t      = 0;
      m_done   = 0;
    end else begin
      m_done = 0;
      if (m_active) begin
        if (!enable) m_active = 0;
        else if (m_t == m_n * SEQ) begin
          m_active = 0;
          m_done   = 1;
        end else m_t = m_t + 1;
      end else if (start && enable) begin
        if (n_bursts != 8'd0) begin
          m_active = 1;
          m_t      = 1;
          m_n      = n_bursts;
        end else m_done = 1;
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic compare_loop();
    logic e_led, e_busy, e_done;
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        e_busy = m_active;
        e_done = m_done;
        e_led  = m_active && (((m_t - 1) % SEQ) < BL) && (((m_t - 1) % PER) < H);
        tests  = tests + 1;
        if ({led_out, busy, done} !== {e_led, e_busy, e_done}) begin
          fails = fails + 1;
          $display("FAIL model cycle %0d: led/busy/done got %b%b%b expected %b%b%b",
                   cyc, led_out, busy, done, e_led, e_busy, e_done);
        end
      end
    end
  endtask

  // Called at a negedge with the DUT idle; cycle 0 is the cycle start is high.
  task automatic run_seq(input int n, input bit en, input int inj_start, input int drop_en,
                         input int maxc, output int done_at, output int busy_cnt,
                         output int led_cnt, output logic [63:0] led_bits,
                         output int done_after);
    done_at    = -1;
    busy_cnt   = 0;
    led_cnt    = 0;
    led_bits   = '0;
    done_after = -1;
    enable     = en;
    start      = 1'b1;
    n_bursts   = n[7:0];
    for (int k = 1; k <= maxc; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) busy_cnt++;
      if (led_out) begin
        led_cnt++;
        if (k < 64) led_bits[k] = 1'b1;
      end
      if (done_at > 0 && k == done_at + 1) begin
        done_after = int'(done);
        break;
      end
      if (done && done_at < 0) done_at = k;
      if (k == inj_start) begin
        start    = 1'b1;
        n_bursts = 8'd5;
      end
      if (k == drop_en) enable = 1'b0;
    end
    start = 1'b0;
  endtask

  initial begin
    int da, bc, lc, dn;
    logic [63:0] lb;
    logic [11:0] pat;
    logic [7:0]  tail;
    int first_run, l2, b2, d2, last_hi;

    rst      = 1'b1;
    enable   = 1'b1;
    start    = 1'b1;
    n_bursts = 8'd1;
    en2      = 1'b0;
    st2      = 1'b0;
    nb2      = 8'd0;
    fork
      compare_loop();
    join_none

    repeat (2) @(negedge clk);
    chk("reset_led", int'(led_out), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    rst   = 1'b0;
    start = 1'b0;
    bc = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy || done || led_out) bc++;
    end
    chk("post_reset_quiet", bc, 0);

    run_seq(1, 1'b1, 0, 0, 40, da, bc, lc, lb, dn);
    pat  = lb[12:1];
    tail = lb[20:13];
    chk("single_done_at", da, 21);
    chk("single_busy_len", bc, 20);
    chk("single_led_pattern", int'(pat), 12'h333);
    chk("single_gap_dark", int'(tail), 0);
    chk("single_done_width", dn, 0);

    @(negedge clk);
    run_seq(2, 1'b1, 0, 0, 80, da, bc, lc, lb, dn);
    chk("multi_done_at", da, 41);
    chk("multi_busy_len", bc, 40);
    chk("multi_led_count", lc, 12);
    chk("multi_burst2_start", int'(lb[21]), 1);
    chk("multi_gap_end_dark", int'(lb[20]), 0);

    @(negedge clk);
    run_seq(0, 1'b1, 0, 0, 10, da, bc, lc, lb, dn);
    chk("zero_done_at", da, 1);
    chk("zero_busy", bc, 0);
    chk("zero_led", lc, 0);

    @(negedge clk);
    run_seq(1, 1'b1, 5, 0, 40, da, bc, lc, lb, dn);
    chk("busy_start_done_at", da, 21);
    chk("busy_start_len", bc, 20);

    @(negedge clk);
    run_seq(3, 1'b1, 0, 5, 80, da, bc, lc, lb, dn);
    chk("abort_no_done", da, -1);
    chk("abort_busy_len", bc, 5);
    chk("abort_led_count", lc, 3);

    run_seq(2, 1'b0, 0, 0, 10, da, bc, lc, lb, dn);
    chk("disabled_start_busy", bc, 0);
    chk("disabled_start_done", da, -1);
    enable = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst      = ($urandom_range(0, 499) == 0);
      start    = ($urandom_range(0, 3) == 0);
      n_bursts = 8'($urandom_range(0, 3));
      enable   = ($urandom_range(0, 63) != 0);
    end
    @(negedge clk);
    rst    = 1'b0;
    start  = 1'b0;
    enable = 1'b1;

    first_run = 0;
    l2 = 0;
    b2 = 0;
    d2 = -1;
    last_hi = 0;
    en2 = 1'b1;
    st2 = 1'b1;
    nb2 = 8'd1;
    for (int k = 1; k <= 7000; k++) begin
      @(negedge clk);
      st2 = 1'b0;
      if (busy2) b2++;
      if (led2) begin
        l2++;
        last_hi = k;
        if (first_run == k - 1) first_run = k;
      end
      if (done2) begin
        d2 = k;
        break;
      end
    end
    chk("default_first_high", first_run, 157);
    chk("default_led_count", l2, 1570);
    chk("default_last_high", last_hi, 2983);
    chk("default_busy_len", b2, 6280);
    chk("default_done_at", d2, 6281);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
